// File: rtl/aurora_seq_pkg.sv
// Shared encodings for the Aurora link bring-up sequencer and its latency meter.
package aurora_seq_pkg;

  typedef enum logic [2:0] {
    ST_PMA  = 3'd0,
    ST_RST  = 3'd1,
    ST_WUP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FAIL = 3'd4
  } seq_state_t;

  localparam int LAT_W = 32;

endpackage

// File: rtl/aurora_lat_meter.sv
// Link latency meter: armed on RUN entry, counts cycles from the first start rising
// edge to the first stop rising edge, saturating at all-ones.
module aurora_lat_meter
  import aurora_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             en,
  input  logic             start_in,
  input  logic             stop_in,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_cycles
);

  logic             start_d, stop_d, armed, running;
  logic             start_rise, stop_rise;
  logic [LAT_W-1:0] cnt;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  assign start_rise = start_in & ~start_d;
  assign stop_rise  = stop_in & ~stop_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_d    <= 1'b0;
      stop_d     <= 1'b0;
      armed      <= 1'b0;
      running    <= 1'b0;
      cnt        <= '0;
      lat_valid  <= 1'b0;
      lat_cycles <= '0;
    end else begin
      start_d <= start_in;
      stop_d  <= stop_in;
      if (arm) begin
        armed      <= 1'b1;
        running    <= 1'b0;
        cnt        <= '0;
        lat_valid  <= 1'b0;
        lat_cycles <= '0;
      end else if (!en) begin
        // Link left RUN: any half-finished measurement is dropped, a finished one is kept.
        armed   <= 1'b0;
        running <= 1'b0;
      end else if (running) begin
        if (stop_rise) begin
          lat_valid  <= 1'b1;
          lat_cycles <= cnt;
          running    <= 1'b0;
          armed      <= 1'b0;
        end else begin
          cnt <= sat_inc(cnt);
        end
      end else if (armed && start_rise) begin
        if (stop_rise) begin
          lat_valid  <= 1'b1;
          lat_cycles <= '0;
          armed      <= 1'b0;
        end else begin
          running <= 1'b1;
          cnt     <= LAT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/aurora_link_sequencer.sv
// Two-core Aurora bring-up sequencer: PMA_INIT/RESET timing, channel-up wait, retries, FAIL.
// Optional latency measurement is compiled in with `define AURORA_SEQ_LATENCY_EN.
module aurora_link_sequencer
  import aurora_seq_pkg::*;
#(
  parameter int PMA_CYCLES  = 160,
  parameter int RST_CYCLES  = 40,
  parameter int WUP_TIMEOUT = 65535,
  parameter int MAX_RETRY   = 3
) (
  input  logic             init_clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             channel_up_0,
  input  logic             channel_up_1,
  input  logic             tx_tvalid_0,
  input  logic             rx_tvalid_1,
  output logic             pma_init,
  output logic             exdes_reset,
  output logic [2:0]       state,
  output logic             link_ok,
  output logic             link_fail,
  output logic [3:0]       retry_cnt,
  output logic             lat_valid,
  output logic [LAT_W-1:0] lat_cycles
);

  localparam int MAX_PH = (PMA_CYCLES > RST_CYCLES)
                          ? ((PMA_CYCLES > WUP_TIMEOUT) ? PMA_CYCLES : WUP_TIMEOUT)
                          : ((RST_CYCLES > WUP_TIMEOUT) ? RST_CYCLES : WUP_TIMEOUT);
  localparam int CNT_W = $clog2(MAX_PH + 1);

  localparam logic [CNT_W-1:0] PMA_LAST  = CNT_W'(PMA_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WUP_LAST  = CNT_W'(WUP_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  seq_state_t       st, nxt;
  logic [CNT_W-1:0] ph_cnt;
  logic [3:0]       retry_nxt;
  logic             both_up, fail_attempt;

  assign both_up = channel_up_0 & channel_up_1;
  assign state   = st;

  always_comb begin
    nxt          = st;
    retry_nxt    = retry_cnt;
    fail_attempt = 1'b0;
    case (st)
      ST_PMA:  if (ph_cnt == PMA_LAST) nxt = ST_RST;
      ST_RST:  if (ph_cnt == RST_LAST) nxt = ST_WUP;
      ST_WUP: begin
        if (both_up)                 nxt = ST_RUN;
        else if (ph_cnt == WUP_LAST) fail_attempt = 1'b1;
      end
      ST_RUN: begin
        // Restart takes precedence over a channel drop in the same cycle.
        if (restart) begin
          nxt       = ST_PMA;
          retry_nxt = '0;
        end else if (!both_up) begin
          fail_attempt = 1'b1;
        end
      end
      ST_FAIL: begin
        if (restart) begin
          nxt       = ST_PMA;
          retry_nxt = '0;
        end
      end
      default: nxt = ST_PMA;
    endcase
    if (fail_attempt) begin
      retry_nxt = retry_cnt + 4'd1;
      nxt       = (retry_nxt == RETRY_LIM) ? ST_FAIL : ST_PMA;
    end
  end

  always_ff @(posedge init_clk) begin
    if (reset) begin
      st          <= ST_PMA;
      ph_cnt      <= '0;
      retry_cnt   <= '0;
      pma_init    <= 1'b1;
      exdes_reset <= 1'b1;
      link_ok     <= 1'b0;
      link_fail   <= 1'b0;
    end else begin
      st        <= nxt;
      retry_cnt <= retry_nxt;
      // Phase counter restarts on every state entry and only runs in the timed states.
      if (nxt != st)
        ph_cnt <= '0;
      else if (st == ST_PMA || st == ST_RST || st == ST_WUP)
        ph_cnt <= ph_cnt + CNT_W'(1);
      pma_init    <= (nxt == ST_PMA);
      exdes_reset <= (nxt inside {ST_PMA, ST_RST, ST_FAIL});
      link_ok     <= (nxt == ST_RUN);
      link_fail   <= (nxt == ST_FAIL);
    end
  end

`ifdef AURORA_SEQ_LATENCY_EN
  logic lat_arm, lat_en;

  assign lat_arm = (nxt == ST_RUN) && (st != ST_RUN);
  assign lat_en  = (st == ST_RUN);

  aurora_lat_meter u_lat_meter (
    .clk       (init_clk),
    .reset     (reset),
    .arm       (lat_arm),
    .en        (lat_en),
    .start_in  (tx_tvalid_0),
    .stop_in   (rx_tvalid_1),
    .lat_valid (lat_valid),
    .lat_cycles(lat_cycles)
  );
`else
  logic unused_tvalid;

  assign unused_tvalid = tx_tvalid_0 ^ rx_tvalid_1;
  assign lat_valid     = 1'b0;
  assign lat_cycles    = '0;
`endif

endmodule
